if_fetch_addr_gen: RTL



---
 rtl/if_pkg.sv | 19 +
 rtl/if_fetch_addr_gen_if.sv | 34 +++
 rtl/if_fetch_fifo.sv | 59 +++++
 rtl/if_fetch_addr_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2
  } fetch_state_e;

  // Default-width view of one response-buffer entry; the top packs entries
  // in the same {addr, rdata} order for any width.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
  } fetch_entry_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_fetch_addr_gen_if.sv
// Instruction-memory bus and decode-side bus of the fetch front end.
interface if_fetch_addr_gen_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  // instr_*: a request transfers on a cycle with instr_req_o && instr_gnt_i;
  // instr_addr_o is held stable while instr_req_o waits for instr_gnt_i, and
  // instr_rvalid_i returns one in-order response per granted request.
  // fetch_*: a word transfers on a cycle with fetch_valid_o && fetch_ready_i;
  // fetch_valid_o never depends combinationally on fetch_ready_i.
  logic                 instr_req_o;
  logic [AddrWidth-1:0] instr_addr_o;
  logic                 instr_gnt_i;
  logic                 instr_rvalid_i;
  logic [DataWidth-1:0] instr_rdata_i;
  logic                 fetch_valid_o;
  logic                 fetch_ready_i;
  logic [DataWidth-1:0] fetch_rdata_o;
  logic [AddrWidth-1:0] fetch_addr_o;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    input  fetch_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    output fetch_ready_i
  );
endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous first-word-fall-through FIFO with flush and occupancy count.
module if_fetch_fifo #(
  parameter  int unsigned Width = 32,
  parameter  int unsigned Depth = 2,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [Width-1:0] data_i,
  input  logic            pop_i,
  output logic [Width-1:0] data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_addr_gen.sv
// IF-stage fetch front end: owns the PC, issues credit-limited memory requests,
// discards responses made stale by redirects and buffers the rest for decode.
module if_fetch_addr_gen
  import if_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] boot_addr_i,
  input  logic                 fetch_enable_i,
  input  logic                 pc_set_i,
  input  logic [AddrWidth-1:0] pc_target_i,
  output logic                 busy_o,
  output fetch_state_e         dbg_state_o,
  if_fetch_addr_gen_if.master  bus
);

  localparam int unsigned CW = $clog2(Depth + 1);

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic                 pend_q, pend_d;
  logic [AddrWidth-1:0] pend_tgt_q, pend_tgt_d;
  logic [CW-1:0]        stale_q, stale_d;

  logic [CW-1:0]        out_cnt, rsp_cnt;
  logic [CW:0]          out_n, rsp_n;
  logic                 credit_n;
  logic                 addr_full, addr_empty, rsp_full, rsp_empty;
  logic [AddrWidth-1:0] addr_head, boot_aligned, tgt_aligned;
  logic                 req, gnt, rv_ok, rsp_push, rsp_pop;
  logic                 unused_low_bits;

  assign boot_aligned    = {boot_addr_i[AddrWidth-1:2], 2'b00};
  assign tgt_aligned     = {pc_target_i[AddrWidth-1:2], 2'b00};
  assign unused_low_bits = ^{boot_addr_i[1:0], pc_target_i[1:0]};

  assign req      = (state_q == REQ);
  assign gnt      = req && bus.instr_gnt_i;
  assign rv_ok    = bus.instr_rvalid_i && !addr_empty;
  assign rsp_push = rv_ok && (stale_q == '0) && !pc_set_i;
  assign rsp_pop  = !rsp_empty && bus.fetch_ready_i && !pc_set_i;

  assign bus.instr_req_o   = req;
  assign bus.instr_addr_o  = pc_q;
  assign bus.fetch_valid_o = !rsp_empty;
  assign busy_o            = req || (out_cnt != '0);
  assign dbg_state_o       = state_q;

  if_fetch_fifo #(.Width(AddrWidth), .Depth(Depth)) u_addr_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (gnt),
    .data_i  (pc_q),
    .pop_i   (rv_ok),
    .data_o  (addr_head),
    .full_o  (addr_full),
    .empty_o (addr_empty),
    .count_o (out_cnt)
  );

  if_fetch_fifo #(.Width(AddrWidth + DataWidth), .Depth(Depth)) u_rsp_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (pc_set_i),
    .push_i  (rsp_push),
    .data_i  ({addr_head, bus.instr_rdata_i}),
    .pop_i   (rsp_pop),
    .data_o  ({bus.fetch_addr_o, bus.fetch_rdata_o}),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .count_o (rsp_cnt)
  );

  // Credit is judged on next-cycle occupancy so a freed slot is reissued at once.
  always_comb begin
    out_n = {1'b0, out_cnt} + (CW+1)'(gnt) - (CW+1)'(rv_ok);
    if (pc_set_i) rsp_n = '0;
    else          rsp_n = {1'b0, rsp_cnt} + (CW+1)'(rsp_push) - (CW+1)'(rsp_pop);
    credit_n = ({1'b0, out_n} + {1'b0, rsp_n}) < (CW+2)'(Depth);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    stale_d    = stale_q;

    unique case (state_q)
      BOOT:    state_d = IDLE;
      IDLE:    if (fetch_enable_i && credit_n) state_d = REQ;
      REQ:     if (gnt && !(fetch_enable_i && credit_n)) state_d = IDLE;
      default: state_d = BOOT;
    endcase

    // A redirect during an ungranted request is parked until that grant.
    if (state_q == BOOT) begin
      pc_d = boot_aligned;
    end else if (pc_set_i && req && !gnt) begin
      pend_d     = 1'b1;
      pend_tgt_d = tgt_aligned;
    end else if (pc_set_i) begin
      pc_d   = tgt_aligned;
      pend_d = 1'b0;
    end else if (gnt) begin
      pc_d   = pend_q ? pend_tgt_q : pc_q + AddrWidth'(PC_INC);
      pend_d = 1'b0;
    end

    if (pc_set_i) begin
      stale_d = CW'(out_n);
    end else begin
      stale_d = stale_q + CW'(gnt && pend_q) - CW'(rv_ok && (stale_q != '0));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      stale_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      stale_q    <= stale_d;
    end
  end

  rvalid_with_nothing_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(bus.instr_rvalid_i && addr_empty));
  addr_queue_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(gnt && addr_full));
  rsp_queue_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(rsp_push && rsp_full));

endmodule
